// File: rtl/adder16_mul_seq_if.sv
// Handshake bundle for the shift-and-add multiplier sequencer.
//   start_valid / start_ready / a / b : operand channel (master -> slave)
//   result_valid / result_ready / result : product channel (slave -> master)
//   busy : sequencer is in RUN or DONE
// master: the requesting side (ALU / testbench); slave: the multiplier.
interface adder16_mul_seq_if;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result;
    logic        busy;

    modport master (
        output start_valid,
        output a,
        output b,
        output result_ready,
        input  start_ready,
        input  result_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  start_valid,
        input  a,
        input  b,
        input  result_ready,
        output start_ready,
        output result_valid,
        output result,
        output busy
    );
endinterface

// File: rtl/adder16_mul_seq.sv
// Adder16: 16-bit ripple-carry adder, carry-out discarded (wraps mod 2^16).
//   a_i, b_i : addends
//   sum_o    : a_i + b_i, low 16 bits
//
// adder16_mul_seq: multi-cycle 16x16 multiplier, low 16 bits of the product,
// computed by shift-and-add with one Adder16 step per cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of adder16_mul_seq_if (operand/result handshakes, busy)
// EARLY_EXIT=1 stops as soon as the remaining multiplier bits are all zero;
// EARLY_EXIT=0 always runs 16 steps.
module Adder16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    logic c;

    always_comb begin
        c     = 1'b0;
        sum_o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
    end
endmodule

module adder16_mul_seq #(
    parameter int EARLY_EXIT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    adder16_mul_seq_if.slave         bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] m_q, m_d;
    logic [15:0] q_q, q_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;

    logic [15:0] sum;
    logic        last_step;

    Adder16 u_add (
        .a_i   (acc_q),
        .b_i   (m_q),
        .sum_o (sum)
    );

    // Exit is judged on the pre-step values, so the step that consumes the
    // final set multiplier bit is the last one.
    always_comb begin
        last_step = (cnt_q == 4'd15);
        if (EARLY_EXIT != 0 && q_q[15:1] == '0) begin
            last_step = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            q_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            q_q      <= q_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        q_d      = q_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    m_d     = bus.a;
                    q_d     = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = q_q[0] ? sum : acc_q;
                m_d   = {m_q[14:0], 1'b0};
                q_d   = {1'b0, q_q[15:1]};
                cnt_d = cnt_q + 4'd1;
                if (last_step) begin
                    result_d = acc_d;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.start_ready  = (state_q == IDLE);
        bus.result_valid = (state_q == DONE);
        bus.busy         = (state_q == RUN) || (state_q == DONE);
        bus.result       = result_q;
    end
endmodule

// File: tb/tb_adder16_mul_seq.sv
module tb_adder16_mul_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    adder16_mul_seq_if bus_f ();
    adder16_mul_seq_if bus_e ();

    adder16_mul_seq #(.EARLY_EXIT(0)) dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    adder16_mul_seq #(.EARLY_EXIT(1)) dut_early (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_e)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        int          n_early;
        bit          junk;
    } vec_t;

    vec_t        tbl [10];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [15:0] da, input logic [15:0] db);
        bus_f.start_valid = sv;
        bus_e.start_valid = sv;
        bus_f.a = da;
        bus_e.a = da;
        bus_f.b = db;
        bus_e.b = db;
    endtask

    task automatic set_ready(input logic r);
        bus_f.result_ready = r;
        bus_e.result_ready = r;
    endtask

    task automatic check_idle(input string name, input logic [15:0] res);
        check({name, " full idle flags"},
              {29'd0, bus_f.start_ready, bus_f.result_valid, bus_f.busy}, 32'h4);
        check({name, " early idle flags"},
              {29'd0, bus_e.start_ready, bus_e.result_valid, bus_e.busy}, 32'h4);
        check({name, " full result"}, {16'd0, bus_f.result}, {16'd0, res});
        check({name, " early result"}, {16'd0, bus_e.result}, {16'd0, res});
    endtask

    // One product on both DUTs in parallel; measures RUN length of each.
    task automatic run_op(input string name, input vec_t v);
        int          n0;
        int          n1;
        logic [15:0] r0;
        logic [15:0] r1;
        n0 = -1;
        n1 = -1;
        r0 = '0;
        r1 = '0;
        @(negedge clk);
        check({name, " start_ready"}, {30'd0, bus_f.start_ready, bus_e.start_ready}, 32'h3);
        drive(1'b1, v.a, v.b);
        @(posedge clk);                     // edge 0: accept
        @(negedge clk);
        drive(1'b0, ~v.a, ~v.b);            // operands change after acceptance
        check({name, " busy/ready after accept"},
              {28'd0, bus_f.busy, bus_e.busy, bus_f.start_ready, bus_e.start_ready}, 32'hC);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);                 // after edge k
            if (n0 < 0 && bus_f.result_valid) begin
                n0 = k;
                r0 = bus_f.result;
            end
            if (n1 < 0 && bus_e.result_valid) begin
                n1 = k;
                r1 = bus_e.result;
            end
            if (n0 >= 0 && n1 >= 0) break;
            if (v.junk && k >= 2) drive(1'b1, 16'(k * 16'h1111), 16'h7777);
        end
        drive(1'b0, '0, '0);
        check({name, " N full"}, n0, 16);
        check({name, " N early"}, n1, v.n_early);
        check({name, " result full"}, {16'd0, r0}, {16'd0, v.prod});
        check({name, " result early"}, {16'd0, r1}, {16'd0, v.prod});
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check({name, " hold full"}, {15'd0, bus_f.result_valid, bus_f.result}, {15'd0, 1'b1, v.prod});
            check({name, " hold early"}, {15'd0, bus_e.result_valid, bus_e.result}, {15'd0, 1'b1, v.prod});
        end
        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(1'b0);
        check_idle({name, " after release"}, v.prod);
    endtask

    initial begin
        int seen;
        tbl[0] = '{a: 16'h0003, b: 16'h0005, prod: 16'h000F, n_early: 3,  junk: 1'b0};
        tbl[1] = '{a: 16'h0007, b: 16'h0005, prod: 16'h0023, n_early: 3,  junk: 1'b1};
        tbl[2] = '{a: 16'h1234, b: 16'h0000, prod: 16'h0000, n_early: 1,  junk: 1'b0};
        tbl[3] = '{a: 16'h0003, b: 16'h8000, prod: 16'h8000, n_early: 16, junk: 1'b1};
        tbl[4] = '{a: 16'h1234, b: 16'h0100, prod: 16'h3400, n_early: 9,  junk: 1'b0};
        tbl[5] = '{a: 16'hFFFF, b: 16'h0003, prod: 16'hFFFD, n_early: 2,  junk: 1'b1};
        tbl[6] = '{a: 16'h8000, b: 16'h0002, prod: 16'h0000, n_early: 2,  junk: 1'b0};
        tbl[7] = '{a: 16'h0000, b: 16'hFFFF, prod: 16'h0000, n_early: 16, junk: 1'b0};
        tbl[8] = '{a: 16'h00FF, b: 16'h00FF, prod: 16'hFE01, n_early: 8,  junk: 1'b1};
        tbl[9] = '{a: 16'hFFFF, b: 16'hFFFF, prod: 16'h0001, n_early: 16, junk: 1'b0};

        drive(1'b0, '0, '0);
        set_ready(1'b0);
        #1 rst_n = 1'b0;
        #2 check_idle("reset", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("v%0d", i), tbl[i]);
        end

        // Reset mid-RUN: asserted asynchronously during step 7 of 16.
        @(negedge clk);
        drive(1'b1, 16'h0001, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, '0);
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle("midrun reset", 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_f.result_valid || bus_e.result_valid || bus_f.busy || bus_e.busy) seen++;
        end
        check("no result after reset", seen, 0);
        run_op("post-reset", '{a: 16'h0002, b: 16'h0009, prod: 16'h0012, n_early: 4, junk: 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
